gyro_rx_deframer: RTL and testbench
===================================

// Module: gyro_rx_deframer
// PURPOSE
//  Receive side of the gyro serial link. Samples DRX/DSYNC on bit ticks and
//  deserializes DSYNC-framed words, MSB first. Buffers the words in a FIFO and
//  presents them as a valid/ready stream to the loop/pattern-check logic.
//  Keeps sticky error flags and frame/drop counters for the register block.
// PARAMETERS
//  WORD_W   32  bits per frame (8..32)
//  DEPTH    16  FIFO depth in words, power of 2
//  THRESH    8  occupancy at which irq_fill asserts (1..DEPTH)
// PORTS
//  ACLK        in   1       system clock, 100 MHz
//  ARESETn     in   1       async active-low reset
//  enable      in   1       receiver enable; low aborts the frame in progress
//  clr         in   1       1-cycle pulse: flush FIFO, clear flags and counters
//  bit_tick    in   1       1-ACLK pulse per bit period, from the link clock gen
//  DRX         in   1       serial data pin, asynchronous
//  DSYNC       in   1       frame sync pin, high on the first bit of a frame
//  m_tdata     out  WORD_W  received word
//  m_tvalid    out  1       word available
//  m_tready    in   1       consumer accepts the word
//  fifo_level  out  $clog2(DEPTH)+1  current occupancy
//  irq_fill    out  1       fifo_level >= THRESH
//  ovf_sticky  out  1       a word was dropped because the FIFO was full
//  frm_sticky  out  1       DSYNC arrived mid-frame
//  frame_cnt   out  16      completed frames; wraps 0xFFFF->0
//  drop_cnt    out  16      dropped words; saturates at 0xFFFF
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in HUNT, and the FIFO is empty.
//  DRX and DSYNC each pass through a 2-FF synchronizer. Only synchronized
//  values are sampled, and only on cycles with bit_tick=1 and enable=1.
//  FSM:
//   HUNT : tick with dsync_s=1 loads bit 1 into the shift register, sets
//          bitcnt=1, goes to SHIFT. Ticks with dsync_s=0 are ignored.
//   SHIFT: each tick shifts in DRX (MSB first) and increments bitcnt.
//          If dsync_s=1 on a tick with bitcnt in 1..WORD_W-1: set frm_sticky,
//          discard the partial word, restart with this bit as bit 1 (bitcnt=1).
//          The tick that brings bitcnt to WORD_W completes the word: go to PUSH.
//   PUSH : one cycle; write the word to the FIFO, increment frame_cnt, go to
//          HUNT. Ticks are never adjacent, so no tick is lost in this cycle.
//  Writing to a full FIFO: the word is dropped, ovf_sticky is set, drop_cnt is
//   incremented, and frame_cnt still increments.
//  Simultaneous write and pop (m_tvalid & m_tready) while full: the write is
//   accepted and the level is unchanged. While empty, no bypass is allowed.
//  Stream rules:
//   - m_tvalid = FIFO not empty; m_tdata is the head word, registered.
//   - m_tdata is held stable while m_tvalid & !m_tready.
//   - Pop happens on m_tvalid & m_tready.
//  Latency: m_tvalid rises exactly 2 ACLK cycles after the cycle holding the
//   last bit's tick (FIFO empty case). Synchronizer delay precedes this.
//  enable low: the FSM returns to HUNT the next cycle and the partial word is
//   lost. FIFO contents, flags and counters are kept, and the output stream
//   keeps draining.
//  clr:
//   - FIFO empty, m_tvalid=0, both sticky flags and both counters = 0, next cycle.
//   - The FSM goes to HUNT.
//   - clr wins over a PUSH in the same cycle: that word is discarded, not counted.
//  irq_fill is combinational from fifo_level. No other outputs are
//   combinational from inputs.
//  An ARESETn assertion mid-frame clears everything immediately (async).
// TESTING
//  1 Single frame 0xA5A51234, DSYNC on bit 31, tick every 4 cycles
//    -> m_tdata=0xA5A51234; m_tvalid 2 cycles after the last tick; frame_cnt=1.
//  2 20 back-to-back frames (0x00000001..0x00000014), m_tready=0
//    -> level=16 and irq_fill=1 from level 8; words 17..20 dropped;
//       ovf_sticky=1, drop_cnt=4, frame_cnt=20; drain reads 1..16 in order.
//  3 DSYNC reasserted at bit 10 of a frame, then a clean 32-bit frame
//    0xDEADBEEF follows -> frm_sticky=1; one word 0xDEADBEEF; frame_cnt=1.
//  4 FIFO full, a PUSH coincides with a pop -> level stays 16, no drop,
//    ovf_sticky=0.
//  5 enable dropped at bit 20, re-enabled, frame 0x12345678 sent -> only
//    0x12345678 received; frm_sticky=0.
//  6 clr pulse with 5 words queued and flags set -> level=0, m_tvalid=0,
//    counters and flags 0; ARESETn pulsed mid-frame -> all outputs 0.

Source files
------------

// File: rtl/gyro_rx_deframer.sv
// Gyro link receiver: synchronizes DRX/DSYNC, deframes DSYNC-delimited words MSB first,
// and queues them in a FIFO presented as a valid/ready stream with sticky flags and counters.
module gyro_rx_deframer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int THRESH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              enable,
    input  logic              clr,
    input  logic              bit_tick,
    input  logic              DRX,
    input  logic              DSYNC,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [LW-1:0]     fifo_level,
    output logic              irq_fill,
    output logic              ovf_sticky,
    output logic              frm_sticky,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } state_e;

    // Handshake: a word transfers on every cycle where m_tvalid & m_tready are both high;
    // m_tdata holds steady while m_tvalid is high and m_tready is low.

    logic [1:0]        drx_sync_q;
    logic [1:0]        dsync_sync_q;
    logic              drx_s;
    logic              dsync_s;
    logic              tick_en;

    state_e            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [CW-1:0]     bitcnt_q;
    logic              frm_q;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_next;
    logic [LW-1:0]     count_q;
    logic [WORD_W-1:0] tdata_q;
    logic              ovf_q;
    logic [15:0]       frame_q;
    logic [15:0]       drop_q;

    logic              push;
    logic              pop;
    logic              full;
    logic              push_acc;
    logic              drop;

    assign drx_s   = drx_sync_q[1];
    assign dsync_s = dsync_sync_q[1];
    assign tick_en = bit_tick & enable;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drx_sync_q   <= 2'b00;
            dsync_sync_q <= 2'b00;
        end else begin
            drx_sync_q   <= {drx_sync_q[0], DRX};
            dsync_sync_q <= {dsync_sync_q[0], DSYNC};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= HUNT;
            shift_q  <= '0;
            bitcnt_q <= '0;
            frm_q    <= 1'b0;
        end else if (clr) begin
            state_q  <= HUNT;
            shift_q  <= '0;
            bitcnt_q <= '0;
            frm_q    <= 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (tick_en && dsync_s) begin
                        shift_q  <= {{(WORD_W-1){1'b0}}, drx_s};
                        bitcnt_q <= CW'(1);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!enable) begin
                        bitcnt_q <= '0;
                        state_q  <= HUNT;
                    end else if (bit_tick) begin
                        if (dsync_s) begin
                            // Sync inside a frame: drop the partial word and treat this bit as the new MSB.
                            frm_q    <= 1'b1;
                            shift_q  <= {{(WORD_W-1){1'b0}}, drx_s};
                            bitcnt_q <= CW'(1);
                        end else begin
                            shift_q  <= {shift_q[WORD_W-2:0], drx_s};
                            bitcnt_q <= bitcnt_q + CW'(1);
                            if (bitcnt_q == CW'(WORD_W - 1)) begin
                                state_q <= PUSH;
                            end
                        end
                    end
                end
                PUSH: begin
                    bitcnt_q <= '0;
                    state_q  <= HUNT;
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign push     = (state_q == PUSH) && !clr;
    assign pop      = m_tvalid && m_tready;
    assign full     = (count_q == LW'(DEPTH));
    assign push_acc = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_next  = rd_ptr_q + AW'(1);

    always_ff @(posedge ACLK) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tdata_q  <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tdata_q  <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_q + LW'(push_acc) - LW'(pop);
            // The head register follows the word that will sit at the read pointer next cycle.
            if (push_acc && (count_q == '0 || (count_q == LW'(1) && pop))) begin
                tdata_q <= shift_q;
            end else if (pop && count_q > LW'(1)) begin
                tdata_q <= mem_q[rd_next];
            end
            if (push) begin
                frame_q <= frame_q + 16'd1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    assign m_tdata    = tdata_q;
    assign m_tvalid   = (count_q != '0);
    assign fifo_level = count_q;
    assign irq_fill   = (count_q >= LW'(THRESH));
    assign ovf_sticky = ovf_q;
    assign frm_sticky = frm_q;
    assign frame_cnt  = frame_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_gyro_rx_deframer.sv
// Bench for gyro_rx_deframer: directed link scenarios plus random words, checked against
// a queue-based model of received words, counters and sticky flags.
module tb_gyro_rx_deframer;

    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        enable;
    logic        clr;
    logic        bit_tick;
    logic        DRX;
    logic        DSYNC;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  fifo_level;
    logic        irq_fill;
    logic        ovf_sticky;
    logic        frm_sticky;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    gyro_rx_deframer dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .enable     (enable),
        .clr        (clr),
        .bit_tick   (bit_tick),
        .DRX        (DRX),
        .DSYNC      (DSYNC),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .fifo_level (fifo_level),
        .irq_fill   (irq_fill),
        .ovf_sticky (ovf_sticky),
        .frm_sticky (frm_sticky),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] exp_q[$];
    int unsigned frames_m;
    int unsigned drops_m;
    logic        ovf_m;
    logic        frm_m;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        exp_q.delete();
        frames_m = 0;
        drops_m  = 0;
        ovf_m    = 1'b0;
        frm_m    = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] w);
        frames_m = (frames_m + 1) % 65536;
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
        end else begin
            ovf_m = 1'b1;
            if (drops_m < 65535) drops_m++;
        end
    endtask

    task automatic check_status(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, "_level"}, 32'(fifo_level), 32'(sz));
        check({tag, "_irq"}, 32'(irq_fill), 32'(sz >= THRESH));
        check({tag, "_valid"}, 32'(m_tvalid), 32'(sz != 0));
        if (sz != 0) check({tag, "_data"}, m_tdata, exp_q[0]);
        check({tag, "_ovf"}, 32'(ovf_sticky), 32'(ovf_m));
        check({tag, "_frm"}, 32'(frm_sticky), 32'(frm_m));
        check({tag, "_frames"}, 32'(frame_cnt), frames_m);
        check({tag, "_drops"}, 32'(drop_cnt), drops_m);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tdata"}, m_tdata, 32'h0);
        check({tag, "_valid"}, 32'(m_tvalid), 32'h0);
        check({tag, "_level"}, 32'(fifo_level), 32'h0);
        check({tag, "_irq"}, 32'(irq_fill), 32'h0);
        check({tag, "_ovf"}, 32'(ovf_sticky), 32'h0);
        check({tag, "_frm"}, 32'(frm_sticky), 32'h0);
        check({tag, "_frames"}, 32'(frame_cnt), 32'h0);
        check({tag, "_drops"}, 32'(drop_cnt), 32'h0);
    endtask

    // One bit period of 4 cycles; the tick lands in the last cycle so the synchronized pins are settled.
    task automatic send_bit(input logic d, input logic s);
        DRX      = d;
        DSYNC    = s;
        bit_tick = 1'b0;
        repeat (3) @(negedge ACLK);
        bit_tick = 1'b1;
        @(negedge ACLK);
        bit_tick = 1'b0;
    endtask

    task automatic send_partial(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[31-i], i == 0);
        DSYNC = 1'b0;
    endtask

    // mode 0: plain, 1: pop coincides with the push, 2: latency check, 3: clr coincides with the push
    task automatic send_word(input logic [31:0] w, input int mode);
        for (int i = 0; i < 32; i++) send_bit(w[31-i], i == 0);
        DSYNC = 1'b0;
        if (mode == 2) check("lat_push_cycle", 32'(m_tvalid), 32'h0);
        if (mode == 1) begin
            check("pop_full_valid", 32'(m_tvalid), 32'h1);
            check("pop_full_data", m_tdata, exp_q[0]);
            m_tready = 1'b1;
        end
        if (mode == 3) clr = 1'b1;
        @(negedge ACLK);
        m_tready = 1'b0;
        clr      = 1'b0;
        if (mode == 1) void'(exp_q.pop_front());
        if (mode == 2) check("lat_valid_rise", 32'(m_tvalid), 32'h1);
        if (mode == 3) model_clear();
        else model_frame(w);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        @(negedge ACLK);
        clr = 1'b0;
        model_clear();
        check_zero(tag);
    endtask

    task automatic drain(input int target);
        logic rdy;
        while (exp_q.size() > target) begin
            check("drain_valid", 32'(m_tvalid), 32'h1);
            check("drain_data", m_tdata, exp_q[0]);
            rdy = 1'($urandom_range(0, 1));
            m_tready = rdy;
            @(negedge ACLK);
            if (rdy) void'(exp_q.pop_front());
        end
        m_tready = 1'b0;
        check_status("drain_end");
    endtask

    initial begin
        ARESETn  = 1'b0;
        enable   = 1'b1;
        clr      = 1'b0;
        bit_tick = 1'b0;
        DRX      = 1'b0;
        DSYNC    = 1'b0;
        m_tready = 1'b0;
        model_clear();
        repeat (3) @(negedge ACLK);
        check_zero("reset");
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Single frame with latency check
        send_word(32'hA5A51234, 2);
        check("t1_tdata", m_tdata, 32'hA5A51234);
        check("t1_frames", 32'(frame_cnt), 32'd1);
        check_status("t1");
        drain(0);

        // Overfill with consumer stalled
        do_clr("t2_clr");
        for (int k = 1; k <= 20; k++) begin
            send_word(32'(k), 0);
            check_status("t2_step");
        end
        check("t2_level", 32'(fifo_level), 32'd16);
        check("t2_irq", 32'(irq_fill), 32'd1);
        check("t2_ovf", 32'(ovf_sticky), 32'd1);
        check("t2_drops", 32'(drop_cnt), 32'd4);
        check("t2_frames", 32'(frame_cnt), 32'd20);
        drain(0);

        // Mid-frame resync followed by a clean frame
        do_clr("t3_clr");
        send_partial($urandom, 10);
        frm_m = 1'b1;
        send_word(32'hDEADBEEF, 0);
        check("t3_frm", 32'(frm_sticky), 32'd1);
        check("t3_tdata", m_tdata, 32'hDEADBEEF);
        check("t3_frames", 32'(frame_cnt), 32'd1);
        check_status("t3");
        drain(0);

        // Push coinciding with a pop while full
        do_clr("t4_clr");
        for (int k = 0; k < 16; k++) send_word($urandom, 0);
        send_word($urandom, 1);
        check("t4_level", 32'(fifo_level), 32'd16);
        check("t4_ovf", 32'(ovf_sticky), 32'd0);
        check("t4_drops", 32'(drop_cnt), 32'd0);
        check_status("t4");
        drain(0);

        // Receiver disabled mid-frame
        do_clr("t5_clr");
        send_partial($urandom, 20);
        enable = 1'b0;
        idle_ticks(4);
        enable = 1'b1;
        send_word(32'h12345678, 0);
        check("t5_frm", 32'(frm_sticky), 32'd0);
        check("t5_tdata", m_tdata, 32'h12345678);
        check_status("t5");
        drain(0);

        // Flags set and 5 words queued, then clr
        do_clr("t6_clr0");
        for (int k = 0; k < 17; k++) send_word($urandom, 0);
        send_partial($urandom, 5);
        frm_m = 1'b1;
        send_word($urandom, 0);
        check_status("t6_full");
        drain(5);
        check("t6_level5", 32'(fifo_level), 32'd5);
        do_clr("t6_clr");

        // clr in the same cycle as a push
        send_word($urandom, 3);
        check_status("clr_push");

        // Random bursts with random consumer backpressure
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) send_word($urandom, 0);
            check_status("rnd_burst");
            drain(0);
        end

        // Asynchronous reset in the middle of a frame
        for (int k = 0; k < 3; k++) send_word($urandom, 0);
        send_partial($urandom, 12);
        #2;
        ARESETn = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        model_clear();
        @(negedge ACLK);
        send_word($urandom, 0);
        check_status("post_rst");
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
